mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide responder for the MIPS multicycle datapath.
- Accepts single-cycle `multStart`/`divStart` pulses from the control unit, with operands taken from the A/B registers.
- Iterates one bit per clock and presents a 64-bit result on HI/LO, with a one-cycle `done` pulse.
- The control unit's `Load_HI`/`Load_LO` capture HI/LO when `done` is high.

---
 rtl/multdiv_pkg.sv | 26 ++
 rtl/div_step.sv | 22 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types, widths and helpers for the multicycle signed multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned LAST_ITER   = 31;
    localparam int unsigned MULTDIV_LAT = 33;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] x);
        return ~x + DATA_W'(1);
    endfunction

    // Unsigned magnitude; the most negative value maps onto itself, which is exact as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? neg_val(x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import multdiv_pkg::*;
(
    input  logic [DATA_W-1:0] rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_nxt_c,
    output logic              q_bit_c
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    assign shifted = {rem, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};

    // Remainder stays below the divisor, so a set top bit of the trial can only mean a borrow.
    assign q_bit_c   = ~trial[DATA_W];
    assign rem_nxt_c = q_bit_c ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide, one bit per clock, result on HI/LO with a done pulse.
// Optional early divide-by-zero completion is enabled by defining MULTDIV_DIVZERO_EN.
module mult_div_unit
    import multdiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              multStart,
    input  logic              divStart,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              busy,
    output logic              done,
    output logic              divZero
);

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd;
    logic                res_neg;
    logic                rem_neg;
    logic                b_zero;
    logic                op_div;

    logic                dz_start_c;
    logic [DATA_W:0]     mult_sum_c;
    logic [2*DATA_W-1:0] mult_nxt_c;
    logic [2*DATA_W-1:0] div_nxt_c;
    logic [2*DATA_W-1:0] prod_neg_c;
    logic [DATA_W-1:0]   div_rem_c;
    logic                div_q_c;

`ifdef MULTDIV_DIVZERO_EN
    assign dz_start_c = divStart && (B == '0);
`else
    assign dz_start_c = 1'b0;
`endif

    // Shift-add: accumulator upper half gathers partial sums, lower half holds the multiplier.
    assign mult_sum_c = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mult_nxt_c = {mult_sum_c, acc[DATA_W-1:1]};
    assign prod_neg_c = ~acc + (2*DATA_W)'(1);

    // Restoring divide: upper half is the remainder, lower half shifts dividend out / quotient in.
    div_step u_div_step (
        .rem          (acc[2*DATA_W-1:DATA_W]),
        .dividend_bit (acc[DATA_W-1]),
        .divisor      (opnd),
        .rem_nxt_c    (div_rem_c),
        .q_bit_c      (div_q_c)
    );

    assign div_nxt_c = {div_rem_c, acc[DATA_W-2:0], div_q_c};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (multStart) begin
                    state_nxt = MULT;
                end else if (divStart) begin
                    state_nxt = dz_start_c ? DONE : DIV;
                end
            end
            MULT, DIV: begin
                if (cnt == '0) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; HI/LO change only on the FIX edge or an early divide-by-zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            b_zero  <= 1'b0;
            op_div  <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divZero <= 1'b0;
            busy    <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (multStart || divStart) begin
                        res_neg <= A[DATA_W-1] ^ B[DATA_W-1];
                        rem_neg <= A[DATA_W-1];
                        b_zero  <= (B == '0);
                        cnt     <= CNT_W'(LAST_ITER);
                    end
                    if (multStart) begin
                        op_div <= 1'b0;
                        opnd   <= abs_val(A);
                        acc    <= {{DATA_W{1'b0}}, abs_val(B)};
                    end else if (divStart) begin
                        op_div <= 1'b1;
                        opnd   <= abs_val(B);
                        acc    <= {{DATA_W{1'b0}}, abs_val(A)};
                        if (dz_start_c) begin
                            HI      <= A;
                            LO      <= '1;
                            done    <= 1'b1;
                            divZero <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc <= mult_nxt_c;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV: begin
                    acc <= div_nxt_c;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (!op_div) begin
                        {HI, LO} <= res_neg ? prod_neg_c : acc;
                    end else begin
                        // A zero divisor yields an all-ones quotient that must not be sign-corrected.
                        LO <= (res_neg && !b_zero) ? neg_val(acc[DATA_W-1:0]) : acc[DATA_W-1:0];
                        HI <= rem_neg ? neg_val(acc[2*DATA_W-1:DATA_W]) : acc[2*DATA_W-1:DATA_W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        multStart;
    logic        divStart;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        divZero;

    int tests;
    int fails;
    bit finished;

    // Reference model state
    int          e;
    int          k;
    int          idle_from;
    int          lat_m;
    bit          active;
    bit          dz_m;
    logic [63:0] cur_res;
    logic [63:0] new_res;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .multStart (multStart),
        .divStart  (divStart),
        .HI        (HI),
        .LO        (LO),
        .busy      (busy),
        .done      (done),
        .divZero   (divZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            qv = 64'(sa * sb);
            return qv;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        r  = sa % sb;
        qv = 64'(q);
        rv = 64'(r);
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // Model: accepts a start when its own timeline says the unit is idle, then predicts outputs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            active    = 1'b0;
            cur_res   = '0;
            idle_from = 0;
        end else begin
            e++;
            if (active && (e - k) > lat_m) begin
                cur_res = new_res;
                active  = 1'b0;
            end
            if (!active && e >= idle_from && (multStart || divStart)) begin
                active  = 1'b1;
                k       = e;
                new_res = ref_result(multStart, A, B);
                lat_m   = 33;
                dz_m    = 1'b0;
`ifdef MULTDIV_DIVZERO_EN
                if (!multStart && B == 32'd0) begin
                    lat_m = 0;
                    dz_m  = 1'b1;
                end
`endif
                idle_from = e + lat_m + 2;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int          m;
        bit          exp_busy;
        bit          exp_done;
        bit          exp_dz;
        logic [63:0] exp_res;
        if (!finished) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_dz   = 1'b0;
            exp_res  = cur_res;
            if (reset) begin
                exp_res = '0;
            end else if (active) begin
                m        = e - k;
                exp_busy = 1'b1;
                exp_done = (m == lat_m);
                exp_dz   = dz_m && (m == lat_m);
                exp_res  = (m >= lat_m) ? new_res : cur_res;
            end
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done", 64'(done), 64'(exp_done));
            chk("divZero", 64'(divZero), 64'(exp_dz));
            chk("HI_LO", {HI, LO}, exp_res);
        end
    end

    task automatic run_op(input bit ms, input bit ds, input logic [31:0] a, input logic [31:0] b,
                          input string name, input bit pin, input logic [63:0] pin_val);
        int n;
        int lat;
        @(negedge clk);
        A = a; B = b; multStart = ms; divStart = ds;
        @(negedge clk);
        multStart = 1'b0; divStart = 1'b0;
        A = $urandom; B = $urandom;
        lat = 33;
`ifdef MULTDIV_DIVZERO_EN
        if (!ms && ds && b == 32'd0) lat = 0;
`endif
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 64'(n), 64'(lat));
        if (pin) chk({name, " result"}, {HI, LO}, pin_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dcount;
        tests = 0; fails = 0; finished = 1'b0;
        e = 0; k = 0; idle_from = 0; lat_m = 33; active = 1'b0; dz_m = 1'b0;
        cur_res = '0; new_res = '0;
        A = '0; B = '0; multStart = 1'b0; divStart = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset state", {31'd0, busy, done, divZero, HI, LO}, '0);
        #1 reset = 1'b0;

        run_op(1, 0, 32'd7, 32'd6, "mul 7*6", 1, 64'd42);
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, "mul min*min", 1, 64'h4000_0000_0000_0000);
        run_op(1, 0, 32'hFFFF_FFFD, 32'd5, "mul -3*5", 1, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1", 1, 64'h0000_0000_8000_0000);
        run_op(0, 1, 32'd9, 32'd0, "div 9/0", 1, 64'h0000_0009_FFFF_FFFF);
        run_op(0, 1, 32'hFFFF_FFF9, 32'd0, "div -7/0", 1, 64'hFFFF_FFF9_FFFF_FFFF);
        run_op(1, 1, 32'd7, 32'd6, "both starts", 1, 64'd42);

        // divStart pulse while busy must be dropped
        @(negedge clk);
        A = 32'd100; B = 32'd3; multStart = 1'b1;
        @(negedge clk);
        multStart = 1'b0;
        repeat (10) @(negedge clk);
        A = 32'd9; B = 32'd0; divStart = 1'b1;
        @(negedge clk);
        divStart = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("busy start ignored done count", 64'(dcount), 64'd1);
        chk("busy start ignored result", {HI, LO}, 64'd300);

        // Reset in the middle of a multiply
        @(negedge clk);
        A = 32'd12345; B = 32'd678; multStart = 1'b1;
        @(negedge clk);
        multStart = 1'b0;
        repeat (15) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset HI_LO", {HI, LO}, '0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("mid reset no done", 64'(dcount), 64'd0);
        run_op(1, 0, 32'd5, 32'd5, "after reset 5*5", 1, 64'd25);

        for (int i = 0; i < 150; i++) begin
            bit ms;
            bit ds;
            ms = 1'($urandom_range(0, 1));
            ds = ms ? 1'($urandom_range(0, 1)) : 1'b1;
            run_op(ms, ds, pick_operand(), pick_operand(), "random", 0, '0);
        end

        repeat (3) @(negedge clk);
        finished = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
